// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    // Mux select encoding, also used to remember the last granted requester.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// 2:1 byte mux of the shared datapath; sel_i picks A (SEL_A) or B (SEL_B).
module mux_rr_arbiter_mux
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    // Pure combinational selection.
    always_comb begin
        y_o = (sel_i == SEL_B) ? b_i : a_i;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 2:1 mux between two valid/ready requesters,
// with bursts of up to MAX_BURST beats per grant and a single output register.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    output logic [WIDTH-1:0] y_o,
    output logic             y_valid_o,
    input  logic             y_ready_i,
    output logic             sel_o,
    output logic [1:0]       grant_o
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic [WIDTH-1:0] mux_y;

    logic       out_free;
    logic       accept;
    logic       burst_last;
    logic       cur_valid;
    logic       other_valid;
    arb_state_e other_state;
    logic       other_sel;

    mux_rr_arbiter_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_i   (a_i),
        .b_i   (b_i),
        .sel_i (sel_o),
        .y_o   (mux_y)
    );

    // Handshake and grant decode; ready depends on state and output stage only.
    always_comb begin
        sel_o       = (state_q == GRANT_B) ? SEL_B : SEL_A;
        grant_o     = {state_q == GRANT_B, state_q == GRANT_A};
        out_free    = !y_valid_q || y_ready_i;
        a_ready_o   = (state_q == GRANT_A) && out_free;
        b_ready_o   = (state_q == GRANT_B) && out_free;
        accept      = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
        burst_last  = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
        cur_valid   = (state_q == GRANT_B) ? b_valid_i : a_valid_i;
        other_valid = (state_q == GRANT_B) ? a_valid_i : b_valid_i;
        other_state = (state_q == GRANT_B) ? GRANT_A : GRANT_B;
        other_sel   = (state_q == GRANT_B) ? SEL_A : SEL_B;
        y_o         = y_q;
        y_valid_o   = y_valid_q;
    end

    // Next-state: tie-break on last grant, burst counting and rotation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (a_valid_i && (!b_valid_i || last_grant_q == SEL_B)) begin
                    state_d      = GRANT_A;
                    last_grant_d = SEL_A;
                    burst_cnt_d  = '0;
                end else if (b_valid_i) begin
                    state_d      = GRANT_B;
                    last_grant_d = SEL_B;
                    burst_cnt_d  = '0;
                end
            end
            GRANT_A, GRANT_B: begin
                if (accept) begin
                    if (burst_last) begin
                        // Wrap; hand over only if the other side is waiting.
                        burst_cnt_d = '0;
                        if (other_valid) begin
                            state_d      = other_state;
                            last_grant_d = other_sel;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (!cur_valid) begin
                    // Dropping valid forfeits the rest of the burst.
                    burst_cnt_d = '0;
                    if (other_valid) begin
                        state_d      = other_state;
                        last_grant_d = other_sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Otherwise stalled by the consumer: hold everything.
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Arbiter state registers; after reset A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_B;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Output stage: load on accept, clear when drained with nothing new.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else if (accept) begin
            y_q       <= mux_y;
            y_valid_q <= 1'b1;
        end else if (y_ready_i) begin
            y_valid_q <= 1'b0;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's 8-bit 2:1 mux datapath between two valid/ready requesters (A, B).
- Drives the mux select, registers the selected byte into a single output stage, and holds a grant for bursts of up to MAX_BURST beats before rotating.
- Sits between two byte producers and one downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester and the output.
- MAX_BURST, 4, maximum beats accepted per grant while the other requester is waiting; legal range 1..255.
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- a_i  input  WIDTH  requester A data.
- a_valid_i  input  1  requester A has data.
- a_ready_o  output  1  A beat accepted when a_valid_i && a_ready_o.
- b_i  input  WIDTH  requester B data.
- b_valid_i  input  1  requester B has data.
- b_ready_o  output  1  B beat accepted when b_valid_i && b_ready_o.
- y_o  output  WIDTH  registered output data.
- y_valid_o  output  1  y_o holds a beat.
- y_ready_i  input  1  consumer accepts the beat when y_valid_o && y_ready_i.
- sel_o  output  1  mux select driven to the datapath; 0 = A, 1 = B.
- grant_o  output  2  one-hot current grant: bit0 = A, bit1 = B; 00 in IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=B (so A wins the first tie), burst_cnt=0, y_o=0, y_valid_o=0, sel_o=0, grant_o=00, a_ready_o=0, b_ready_o=0.
- States: IDLE, GRANT_A, GRANT_B. sel_o=1 only in GRANT_B; otherwise 0. grant_o decodes directly from state.
- Output stage free: out_free = !y_valid_o || y_ready_i.
- a_ready_o = (state==GRANT_A) && out_free; b_ready_o = (state==GRANT_B) && out_free.
- Ready never depends combinationally on the same requester's valid.
- Accept: on an accepted beat, y_o <= mux output (A or B data per sel_o) and y_valid_o <= 1.
- If y_ready_i is high and no beat is accepted, y_valid_o <= 0.
- Simultaneous drain and accept is a full-throughput pass: y_valid_o stays 1.
- Throughput is 1 beat/cycle while granted and the consumer is ready.
- Latency is 1 cycle from input accept to y_valid_o.
- IDLE transitions:
  - Only A valid -> GRANT_A.
  - Only B valid -> GRANT_B.
  - Both valid -> the one that is not last_grant.
  - Neither valid -> stay in IDLE.
  - No beat is accepted in IDLE, so each grant entry costs a 1-cycle bubble.
- GRANT_X transitions (X = current requester, Y = other):
  - Entering GRANT_X: last_grant <= X and burst_cnt <= 0.
  - On accept: burst_cnt increments.
  - Accept with burst_cnt == MAX_BURST-1 and Y valid: go directly to GRANT_Y with burst_cnt=0. No IDLE bubble.
  - Accept with burst_cnt == MAX_BURST-1 and Y not valid: stay in GRANT_X, burst_cnt wraps to 0. A lone requester is never starved.
  - X valid low and Y valid: go to GRANT_Y.
  - X valid low and Y not valid: go to IDLE.
  - Output back-pressure (no accept): hold state and burst_cnt; no rotation while stalled.
- Boundary cases:
  - MAX_BURST=1 gives strict alternation whenever both requesters are valid.
  - A requester dropping valid mid-burst forfeits the rest of its burst.
  - Reset asserted mid-burst discards the pending output beat immediately.
- Requesters must hold data stable while valid && !ready. The bench asserts this; the block does not check it.

Decomposition:
- Package mux_arb_pkg:
  - arb_state_e enum {IDLE, GRANT_A, GRANT_B}.
  - SEL_A=1'b0 and SEL_B=1'b1 constants.
  - Default MAX_BURST constant.
- Sub-module: instantiate the existing mux (a_i, b_i, sel_i, y_o) for data selection, driven by sel_o.
- Arbiter FSM, burst counter and output register live in mux_rr_arbiter.

Test Plan:
- Reset: reset_n=0 mid-operation with y_valid_o=1 -> all outputs 0 and grant_o=00 immediately (async); after release, first tie goes to A.
- Single requester: A streams 0x11..0x18 with y_ready_i=1 and B idle -> y_o shows 0x11..0x18 on consecutive cycles after 1 bubble; grant_o=01 throughout; no rotation despite wrapping at 4.
- Contention, MAX_BURST=4: A streams 0xA0.. and B streams 0xB0.. continuously -> outputs A0,A1,A2,A3,B0,B1,B2,B3,A4…; sel_o toggles at each group boundary with no bubble.
- Back-pressure: y_ready_i=0 for 3 cycles during A's 2nd beat -> y_o holds 0xA1, a_ready_o=0, burst_cnt holds; on release, A still gets beats 3 and 4 before B.
- Early drop: A drops valid after 2 beats while B valid -> next cycle grant_o=10, sel_o=1, and B's beat appears 1 cycle after acceptance.
- MAX_BURST=1: both valid -> strict A,B,A,B ordering.
